xi_node_mem_arb: RTL and testbench

XI_NODE_MEM_ARB -- requirements
Module: xi_node_mem_arb

---
 rtl/xi_mem_pkg.sv | 27 ++
 rtl/xi_node_mem_arb_rr.sv | 36 +++
 rtl/xi_node_mem_arb.sv | 115 +++++++++++
 tb/tb_xi_node_mem_arb.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/xi_mem_pkg.sv
// xi_mem_pkg: shared node-memory constants, node word layout, request type and helpers.
//   XI_ADDR_W / XI_DATA_W : default node address / word widths
//   *_LSB / *_W           : field positions inside a node word
//   xi_req_t              : one requester's request bundle
//   sat_inc               : 32-bit saturating increment
package xi_mem_pkg;
    localparam int XI_ADDR_W = 16;
    localparam int XI_DATA_W = 160;
    localparam int TAG_LSB   = 156;
    localparam int TAG_W     = 4;
    localparam int ARITY_LSB = 152;
    localparam int ARITY_W   = 4;
    localparam int PRIM_LSB  = 144;
    localparam int PRIM_W    = 8;
    localparam int CHILD_LSB = 80;
    localparam int CHILD_W   = 64;
    localparam int DATA_LSB  = 0;
    localparam int DATA_FW   = 80;
    typedef struct packed {
        logic                 we;
        logic [XI_ADDR_W-1:0] addr;
        logic [XI_DATA_W-1:0] wdata;
    } xi_req_t;
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction
endpackage

// File: rtl/xi_node_mem_arb_rr.sv
// xi_rr_arbiter: N-wide round-robin arbiter, one-hot grant, pointer = last granted port.
//   clk, rst_n : clock, async active-low reset (port 0 first after reset)
//   valid_i    : per-port request
//   gnt_o      : one-hot grant (zero when no request)
//   idx_o      : index of the granted port
module xi_rr_arbiter #(
    parameter int N = 4,
    localparam int PW = N > 1 ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  valid_i,
    output logic [N-1:0]  gnt_o,
    output logic [PW-1:0] idx_o
);
    logic [PW-1:0] ptr_q, ptr_d;

    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(ptr_q) + k) % N;
            if (gnt_o == '0 && valid_i[j]) begin
                gnt_o[j] = 1'b1;
                idx_o    = PW'(j);
            end
        end
        ptr_d = |valid_i ? idx_o : ptr_q;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ptr_q <= PW'(N - 1);
        else        ptr_q <= ptr_d;
endmodule

// File: rtl/xi_node_mem_arb.sv
// xi_node_mem_arb: N-port round-robin arbitrated node memory with pipelined reads.
//   clk, rst_n            : clock, async active-low reset
//   req_valid/we/addr/wdata : per-port requests (held until granted)
//   req_ready             : one-hot grant this cycle
//   rsp_valid / rsp_data  : per-port read response, RD_LAT cycles after grant
//   stat_*                : saturating read / write / conflict counters
//   err_oor               : sticky out-of-range access flag
module xi_node_mem_arb
    import xi_mem_pkg::*;
#(
    parameter int N_PORTS   = 4,
    parameter int ADDR_W    = XI_ADDR_W,
    parameter int DATA_W    = XI_DATA_W,
    parameter int MEM_DEPTH = 4096,
    parameter int RD_LAT    = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_PORTS-1:0]          req_valid,
    output logic [N_PORTS-1:0]          req_ready,
    input  logic [N_PORTS-1:0]          req_we,
    input  logic [N_PORTS*ADDR_W-1:0]   req_addr,
    input  logic [N_PORTS*DATA_W-1:0]   req_wdata,
    output logic [N_PORTS-1:0]          rsp_valid,
    output logic [N_PORTS*DATA_W-1:0]   rsp_data,
    output logic [31:0]                 stat_reads,
    output logic [31:0]                 stat_writes,
    output logic [31:0]                 stat_conflicts,
    output logic                        err_oor
);
    localparam int PW = N_PORTS > 1 ? $clog2(N_PORTS) : 1;
    localparam int MW = MEM_DEPTH > 1 ? $clog2(MEM_DEPTH) : 1;

    logic [N_PORTS-1:0]        gnt;
    logic [PW-1:0]             gidx;
    logic                      any, sel_we, in_range;
    logic [ADDR_W-1:0]         sel_addr;
    logic [DATA_W-1:0]         sel_wdata;
    logic [DATA_W-1:0]         mem_q [MEM_DEPTH];
    logic [RD_LAT-1:0]         pv_q;
    logic [PW-1:0]             pp_q [RD_LAT];
    logic [DATA_W-1:0]         pd_q [RD_LAT];
    logic [N_PORTS*DATA_W-1:0] rsp_data_q;
    logic [31:0]               rd_q, wr_q, cf_q;
    logic                      err_q;

    xi_rr_arbiter #(.N(N_PORTS)) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (req_valid),
        .gnt_o   (gnt),
        .idx_o   (gidx)
    );

    assign req_ready = gnt;
    assign any       = |gnt;
    assign sel_we    = req_we[gidx];
    assign sel_addr  = req_addr[gidx*ADDR_W +: ADDR_W];
    assign sel_wdata = req_wdata[gidx*DATA_W +: DATA_W];
    assign in_range  = 32'(sel_addr) < MEM_DEPTH;

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk)
        if (any && sel_we && in_range) mem_q[MW'(sel_addr)] <= sel_wdata;

    // Stage 0 is the RAM read register; a write committed at an earlier edge is
    // already visible, which gives read-after-write coherence.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            pv_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pp_q[i] <= '0;
                pd_q[i] <= '0;
            end
        end else begin
            pv_q[0] <= any && !sel_we;
            pp_q[0] <= gidx;
            pd_q[0] <= in_range ? mem_q[MW'(sel_addr)] : '0;
            for (int i = 1; i < RD_LAT; i++) begin
                pv_q[i] <= pv_q[i-1];
                pp_q[i] <= pp_q[i-1];
                pd_q[i] <= pd_q[i-1];
            end
        end

    // The final stage drives its port directly; other ports show their held value.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = rsp_data_q;
        if (pv_q[RD_LAT-1]) begin
            rsp_valid[pp_q[RD_LAT-1]]                   = 1'b1;
            rsp_data[pp_q[RD_LAT-1]*DATA_W +: DATA_W] = pd_q[RD_LAT-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rsp_data_q <= '0;
            rd_q       <= '0;
            wr_q       <= '0;
            cf_q       <= '0;
            err_q      <= 1'b0;
        end else begin
            rsp_data_q <= rsp_data;
            rd_q       <= sat_inc(rd_q, any && !sel_we);
            wr_q       <= sat_inc(wr_q, any && sel_we);
            cf_q       <= sat_inc(cf_q, $countones(req_valid) > 1);
            err_q      <= err_q | (any && !in_range);
        end

    assign stat_reads     = rd_q;
    assign stat_writes    = wr_q;
    assign stat_conflicts = cf_q;
    assign err_oor        = err_q;
endmodule

// File: tb/tb_xi_node_mem_arb.sv
// tb_xi_node_mem_arb: directed bench driving three instances (RD_LAT 1, 2, 3) with shared stimulus.
module tb_xi_node_mem_arb;
    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req_valid, req_we;
    logic [63:0]  req_addr;
    logic [639:0] req_wdata;
    logic [3:0]   rdy  [3];
    logic [3:0]   rv   [3];
    logic [639:0] rdat [3];
    logic [31:0]  sr [3], sw [3], sc [3];
    logic         err [3];
    int           n_vec = 0;
    int           n_err = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        xi_node_mem_arb #(.RD_LAT(g + 1)) u_dut (
            .clk            (clk),
            .rst_n          (rst_n),
            .req_valid      (req_valid),
            .req_ready      (rdy[g]),
            .req_we         (req_we),
            .req_addr       (req_addr),
            .req_wdata      (req_wdata),
            .rsp_valid      (rv[g]),
            .rsp_data       (rdat[g]),
            .stat_reads     (sr[g]),
            .stat_writes    (sw[g]),
            .stat_conflicts (sc[g]),
            .err_oor        (err[g])
        );
    end

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear();
        req_valid = '0;
        req_we    = '0;
        req_addr  = '0;
        req_wdata = '0;
    endtask

    task automatic txn(input int p, input logic we, input logic [15:0] a, input logic [159:0] d);
        logic [3:0] m;
        m = 4'b1 << p;
        @(negedge clk);
        clear();
        req_valid[p]           = 1'b1;
        req_we[p]              = we;
        req_addr[p*16 +: 16]   = a;
        req_wdata[p*160 +: 160] = d;
        #1;
        for (int g = 0; g < 3; g++) chk("req_ready", rdy[g], m);
    endtask

    task automatic expect_rsp(input int p, input logic [159:0] d);
        logic [3:0] m;
        m = 4'b1 << p;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            clear();
            #1;
            for (int g = 0; g < 3; g++) begin
                chk($sformatf("rsp_valid lat%0d c%0d", g + 1, c), rv[g], (c == g + 1) ? m : 4'b0);
                if (c >= g + 1) chk($sformatf("rsp_data lat%0d c%0d", g + 1, c), rdat[g][p*160 +: 160], d);
            end
        end
    endtask

    task automatic chk_stats(input string tag, input int r, input int w, input int cf);
        for (int g = 0; g < 3; g++) begin
            chk({tag, " stat_reads"}, sr[g], r);
            chk({tag, " stat_writes"}, sw[g], w);
            chk({tag, " stat_conflicts"}, sc[g], cf);
        end
    endtask

    initial begin
        clear();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk_stats("reset", 0, 0, 0);
        for (int g = 0; g < 3; g++) begin
            chk("reset err_oor", err[g], 0);
            chk("reset rsp_valid", rv[g], 0);
            chk("reset rsp_data", rdat[g][159:0], 0);
        end
        rst_n = 1'b1;

        txn(0, 1'b1, 16'd2, 160'd42);
        txn(0, 1'b0, 16'd2, 160'd0);
        expect_rsp(0, 160'd42);
        chk_stats("wr_rd", 1, 1, 0);

        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k <= 8; k++) begin
            @(negedge clk);
            clear();
            if (k < 8) begin
                req_valid = 4'hF;
                req_addr  = {4{16'd2}};
            end
            #1;
            if (k < 8) for (int g = 0; g < 3; g++) chk($sformatf("rr grant k%0d", k), rdy[g], 4'b1 << (k % 4));
            if (k > 0) begin
                chk($sformatf("rr rsp_valid k%0d", k), rv[0], 4'b1 << ((k - 1) % 4));
                chk($sformatf("rr rsp_data k%0d", k), rdat[0][((k - 1) % 4)*160 +: 160], 160'd42);
            end
        end
        chk_stats("rr", 8, 0, 8);
        repeat (3) @(negedge clk);

        txn(1, 1'b1, 16'd5, 160'hA5);
        txn(2, 1'b0, 16'd5, 160'd0);
        expect_rsp(2, 160'hA5);

        for (int g = 0; g < 3; g++) chk("pre oor err_oor", err[g], 0);
        txn(0, 1'b1, 16'd0, 160'h11);
        txn(0, 1'b0, 16'd4096, 160'd0);
        expect_rsp(0, 160'd0);
        for (int g = 0; g < 3; g++) chk("oor read err_oor", err[g], 1);
        txn(3, 1'b1, 16'd4096, 160'hFF);
        txn(0, 1'b0, 16'd0, 160'd0);
        expect_rsp(0, 160'h11);
        for (int g = 0; g < 3; g++) chk("oor sticky err_oor", err[g], 1);

        txn(0, 1'b0, 16'd2, 160'd0);
        @(negedge clk);
        clear();
        rst_n = 1'b0;
        #1;
        for (int g = 0; g < 3; g++) chk("mid reset rsp_valid", rv[g], 0);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            #1;
            for (int g = 0; g < 3; g++) chk($sformatf("post reset rsp_valid lat%0d c%0d", g + 1, c), rv[g], 0);
        end
        chk_stats("post reset", 0, 0, 0);
        for (int g = 0; g < 3; g++) chk("post reset err_oor", err[g], 0);
        txn(1, 1'b0, 16'd2, 160'd0);
        expect_rsp(1, 160'd42);
        txn(2, 1'b0, 16'd5, 160'd0);
        expect_rsp(2, 160'hA5);
        chk_stats("after reread", 2, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
